// File: rtl/memory_bus_master_pkg.sv
// memory_bus_master_pkg: shared state encoding and default widths for the memory bus master
package memory_bus_master_pkg;
  localparam int ADDR_BUS_W = 32;
  localparam int DATA_BUS_W = 8;
  localparam int TIMEOUT_CYCLES_DEF = 16;
  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RECOVER
  } state_e;
endpackage

// File: rtl/memory_bus_master_if.sv
// memory_bus_master_if: client request/response handshake plus the strobe/address side of the memory bus
interface memory_bus_master_if import memory_bus_master_pkg::*; #(
  parameter int AW = ADDR_BUS_W,
  parameter int DW = DATA_BUS_W
);
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic [AW-1:0] addr_bus;
  logic          wr_bus;
  logic          rd_bus;
  logic          fc_bus;
  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, fc_bus,
    output req_ready, resp_valid, resp_rdata, resp_err, addr_bus, wr_bus, rd_bus
  );
  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, fc_bus,
    input  req_ready, resp_valid, resp_rdata, resp_err, addr_bus, wr_bus, rd_bus
  );
endinterface

// File: rtl/memory_bus_master_bus_timeout_counter.sv
// bus_timeout_counter: counts strobe cycles and flags the edge on which the count reaches TIMEOUT_CYCLES
module bus_timeout_counter import memory_bus_master_pkg::*; #(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt_q, cnt_d, cnt_inc;
  assign cnt_inc = cnt_q + 1'b1;
  assign cnt_d = clear_i ? '0 : en_i ? cnt_inc : cnt_q;
  assign expired_o = en_i && cnt_inc == W'(TIMEOUT_CYCLES);
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/memory_bus_master.sv
// memory_bus_master: single-transfer bus initiator with write recovery and no-responder timeout
module memory_bus_master import memory_bus_master_pkg::*; #(
  parameter int ADDR_BUS_WIDTH = ADDR_BUS_W,
  parameter int DATA_BUS_WIDTH = DATA_BUS_W,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  memory_bus_master_if.master       bus,
  inout  wire  [DATA_BUS_WIDTH-1:0] data_bus
);
  state_e state_q, state_d;
  logic [ADDR_BUS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_BUS_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic valid_q, valid_d, err_q, err_d;
  logic idle, busy, expired;
  assign idle = state_q == IDLE;
  assign busy = state_q == READ || state_q == WRITE;
  bus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (!busy),
    .en_i      (busy),
    .expired_o (expired)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d = err_q;
    valid_d = 1'b0;
    if (idle && bus.req_valid) begin
      state_d = bus.req_wr ? WRITE : READ;
      addr_d = bus.req_addr;
      wdata_d = bus.req_wdata;
    end else if (busy && bus.fc_bus == 1'b1) begin
      state_d = state_q == READ ? IDLE : RECOVER;
      valid_d = 1'b1;
      err_d = 1'b0;
      rdata_d = state_q == READ ? data_bus : rdata_q;
    end else if (expired) begin
      state_d = RECOVER;
      valid_d = 1'b1;
      err_d = 1'b1;
      rdata_d = '0;
    end else if (state_q == RECOVER) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  end
  assign bus.req_ready = idle && !rst;
  assign bus.resp_valid = valid_q && !rst;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err = err_q;
  assign bus.addr_bus = addr_q;
  assign bus.rd_bus = state_q == READ;
  assign bus.wr_bus = state_q == WRITE;
  assign data_bus = state_q == WRITE ? wdata_q : 'z;
endmodule
